// File: rtl/dpc_pkg.sv
// Shared definitions for the dead-pixel corrector: register byte offsets, AXI response code
// and the packed {col, row} coordinate layout used by the bad-pixel table.
package dpc_pkg;

    localparam logic [9:0] REG_CTRL     = 10'h000;
    localparam logic [9:0] REG_COUNT    = 10'h004;
    localparam logic [9:0] REG_LUT_BASE = 10'h008;
    localparam logic [9:0] REG_STATUS   = 10'h3FC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [15:0] col;
        logic [15:0] row;
    } coord_t;

endpackage

// File: rtl/dpc_axil_regs.sv
// AXI4-Lite slave of the dead-pixel corrector: holds CTRL.GO, COUNT and the bad-pixel LUT,
// and returns any register (including the externally supplied status word) on reads.
module dpc_axil_regs
    import dpc_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BAD        = 64,
    parameter int LUT_AW         = $clog2(MAX_BAD),
    parameter int CNT_W          = $clog2(MAX_BAD + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [31:0]               wdata_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    output logic [31:0]               rdata_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic                      go_o,
    output logic [CNT_W-1:0]          count_o,
    input  logic [LUT_AW-1:0]         lut_idx_i,
    output logic [31:0]               lut_data_o,
    input  logic [31:0]               status_i
);

    localparam logic [7:0] W_CTRL   = REG_CTRL[9:2];
    localparam logic [7:0] W_COUNT  = REG_COUNT[9:2];
    localparam logic [7:0] W_STATUS = REG_STATUS[9:2];
    localparam logic [7:0] W_LUT_LO = REG_LUT_BASE[9:2];
    localparam logic [7:0] W_LUT_HI = W_LUT_LO + 8'(MAX_BAD);

    logic             aw_q, bvalid_q, ar_q, rvalid_q, go_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      lut_q [MAX_BAD];
    logic [7:0]       wr_word, rd_word;
    logic             wr_fire, rd_fire;
    logic             unused_ok;

    assign wr_word = awaddr_i[9:2];
    assign rd_word = araddr_i[9:2];
    assign wr_fire = aw_q & awvalid_i & wvalid_i;
    assign rd_fire = ar_q & arvalid_i;

    always_comb begin
        rdata_d = '0;
        if (rd_word == W_CTRL)
            rdata_d = {31'b0, go_q};
        else if (rd_word == W_COUNT)
            rdata_d = 32'(count_q);
        else if (rd_word == W_STATUS)
            rdata_d = status_i;
        else if (rd_word >= W_LUT_LO && rd_word < W_LUT_HI)
            rdata_d = lut_q[LUT_AW'(rd_word - W_LUT_LO)];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_q     <= 1'b0;
            bvalid_q <= 1'b0;
            ar_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            go_q     <= 1'b0;
            count_q  <= '0;
            // NOTE: the table is reset so a stale entry can never match after reset; this keeps it in flops rather than RAM.
            for (int i = 0; i < MAX_BAD; i++) lut_q[i] <= '0;
        end else begin
            // awready/wready pulse once per write and stay low while the response is pending
            aw_q <= awvalid_i & wvalid_i & ~aw_q & ~bvalid_q;
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (bvalid_q & bready_i)
                bvalid_q <= 1'b0;

            if (wr_fire) begin
                if (wr_word == W_CTRL)
                    go_q <= wdata_i[0];
                else if (wr_word == W_COUNT)
                    count_q <= (wdata_i > 32'(MAX_BAD)) ? CNT_W'(MAX_BAD) : CNT_W'(wdata_i);
                else if (wr_word >= W_LUT_LO && wr_word < W_LUT_HI)
                    lut_q[LUT_AW'(wr_word - W_LUT_LO)] <= wdata_i;
            end

            ar_q <= arvalid_i & ~ar_q & ~rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (rvalid_q & rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign awready_o  = aw_q;
    assign wready_o   = aw_q;
    assign bvalid_o   = bvalid_q;
    assign arready_o  = ar_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign go_o       = go_q;
    assign count_o    = count_q;
    assign lut_data_o = lut_q[lut_idx_i];
    assign unused_ok  = ^{awaddr_i[AXI_ADDR_WIDTH-1:10], awaddr_i[1:0],
                          araddr_i[AXI_ADDR_WIDTH-1:10], araddr_i[1:0]};

endmodule

// File: rtl/dpc_top.sv
// Inline dead-pixel corrector: 1-beat AXI4-Stream pipeline replacing listed pixels with the last good one.
// Optional build macro DPC_STATUS_EN adds a per-frame corrected-pixel counter readable at 0x3FC.
module dpc_top
    import dpc_pkg::*;
#(
    parameter int ROW              = 512,
    parameter int COL              = 640,
    parameter int AXIS_TDATA_WIDTH = 14,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int MAX_BAD          = 64
) (
    input  logic                        axis_aclk,
    input  logic                        axis_areset,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tuser,
    input  logic                        s_axis_tlast,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    input  logic [AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                  s00_axi_awprot,
    input  logic                        s00_axi_awvalid,
    output logic                        s00_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                  s00_axi_wstrb,
    input  logic                        s00_axi_wvalid,
    output logic                        s00_axi_wready,
    output logic [1:0]                  s00_axi_bresp,
    output logic                        s00_axi_bvalid,
    input  logic                        s00_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                  s00_axi_arprot,
    input  logic                        s00_axi_arvalid,
    output logic                        s00_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                  s00_axi_rresp,
    output logic                        s00_axi_rvalid,
    input  logic                        s00_axi_rready
);

    localparam int COL_W  = $clog2(COL);
    localparam int ROW_W  = $clog2(ROW);
    localparam int LUT_AW = $clog2(MAX_BAD);
    localparam int CNT_W  = $clog2(MAX_BAD + 1);

    logic                        go_reg;
    logic [CNT_W-1:0]            count_reg;
    logic [31:0]                 lut_rd, status;
    logic                        go_lat_q, go_eff;
    logic [CNT_W-1:0]            count_lat_q, count_eff, ptr_q, ptr_eff;
    logic [COL_W-1:0]            col_q, col_eff;
    logic [ROW_W-1:0]            row_q, row_eff;
    logic [AXIS_TDATA_WIDTH-1:0] last_good_q, m_tdata_q;
    logic                        m_tvalid_q, m_tuser_q, m_tlast_q;
    logic                        accept, match;
    coord_t                      cur;
    logic                        unused_ok;

    dpc_axil_regs #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .MAX_BAD        (MAX_BAD)
    ) u_regs (
        .clk_i      (axis_aclk),
        .rst_i      (axis_areset),
        .awaddr_i   (s00_axi_awaddr),
        .awvalid_i  (s00_axi_awvalid),
        .awready_o  (s00_axi_awready),
        .wdata_i    (s00_axi_wdata),
        .wvalid_i   (s00_axi_wvalid),
        .wready_o   (s00_axi_wready),
        .bvalid_o   (s00_axi_bvalid),
        .bready_i   (s00_axi_bready),
        .araddr_i   (s00_axi_araddr),
        .arvalid_i  (s00_axi_arvalid),
        .arready_o  (s00_axi_arready),
        .rdata_o    (s00_axi_rdata),
        .rvalid_o   (s00_axi_rvalid),
        .rready_i   (s00_axi_rready),
        .go_o       (go_reg),
        .count_o    (count_reg),
        .lut_idx_i  (ptr_eff[LUT_AW-1:0]),
        .lut_data_o (lut_rd),
        .status_i   (status)
    );

    assign s_axis_tready = ~m_tvalid_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // A tuser beat is (0,0) of a new frame and sees freshly sampled GO/COUNT and a rewound pointer.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch can be inferred.
        col_eff   = s_axis_tuser ? '0 : col_q;
        row_eff   = s_axis_tuser ? '0 : row_q;
        go_eff    = s_axis_tuser ? go_reg : go_lat_q;
        count_eff = s_axis_tuser ? count_reg : count_lat_q;
        ptr_eff   = s_axis_tuser ? '0 : ptr_q;
        cur.col   = 16'(col_eff);
        cur.row   = 16'(row_eff);
        match     = go_eff & (ptr_eff < count_eff) & (lut_rd == cur);
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            go_lat_q    <= 1'b0;
            count_lat_q <= '0;
            ptr_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            last_good_q <= '0;
            m_tvalid_q  <= 1'b0;
            m_tuser_q   <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
        end else if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tuser_q  <= s_axis_tuser;
            m_tlast_q  <= s_axis_tlast;
            m_tdata_q  <= match ? last_good_q : s_axis_tdata;
            if (!match)
                last_good_q <= s_axis_tdata;
            ptr_q <= ptr_eff + CNT_W'(match);
            if (s_axis_tuser) begin
                go_lat_q    <= go_reg;
                count_lat_q <= count_reg;
            end
            if (s_axis_tlast) begin
                col_q <= '0;
                row_q <= row_eff + ROW_W'(1);
            end else begin
                col_q <= col_eff + COL_W'(1);
                row_q <= row_eff;
            end
        end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

`ifdef DPC_STATUS_EN
    logic [31:0] stat_q;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset)
            stat_q <= '0;
        else if (accept) begin
            if (s_axis_tuser)
                stat_q <= {31'b0, match};
            else if (match && stat_q != '1)
                stat_q <= stat_q + 32'd1;
        end
    end

    assign status = stat_q;
`else
    assign status = '0;
`endif

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tdata  = m_tdata_q;
    assign s00_axi_bresp = RESP_OKAY;
    assign s00_axi_rresp = RESP_OKAY;
    assign unused_ok     = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb};

endmodule

// File: tb/tb_dpc_top.sv
// Scoreboard bench for dpc_top: reference model of last-good substitution, small raster frames.
module tb_dpc_top;

    localparam int TW = 14;
    localparam int H  = 8;
    localparam int W  = 12;

    typedef struct {
        logic [TW-1:0] d;
        logic          u;
        logic          l;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_tvalid, s_tready, s_tuser, s_tlast;
    logic [TW-1:0] s_tdata;
    logic          m_tvalid, m_tready, m_tuser, m_tlast;
    logic [TW-1:0] m_tdata;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [TW-1:0] model_lg = '0;
    int            bad_r[5];
    int            bad_c[5];
    int            bad_n = 0;

    always #5 clk = ~clk;

    dpc_top dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tuser    (s_tuser),
        .s_axis_tlast    (s_tlast),
        .s_axis_tdata    (s_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tuser    (m_tuser),
        .m_axis_tlast    (m_tlast),
        .m_axis_tdata    (m_tdata),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (3'b000),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (4'hF),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (3'b000),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    function automatic logic [TW-1:0] pix(input int f, input int r, input int c);
        return TW'(r * 37 + c * 11 + f * 5 + 1);
    endfunction

    function automatic bit is_bad(input int r, input int c);
        for (int i = 0; i < bad_n; i++)
            if (bad_r[i] == r && bad_c[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL axi_write_ready addr=%0h: awready=%0b wready=%0b, expected 1/1", addr, awready, wready);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL axi_write_resp addr=%0h: bvalid=%0b awready=%0b bresp=%0b, expected 1/0/00", addr, bvalid, awready, bresp);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        data = 'x;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL axi_read_ready addr=%0h: arready=%0b, expected 1", addr, arready);
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL axi_read_resp addr=%0h: rvalid=%0b rresp=%0b, expected 1/00", addr, rvalid, rresp);
        end
        data = rdata;
    endtask

    // Streams one HxW frame; the model predicts each output beat as it is accepted.
    task automatic run_frame(input int f, input bit go_m, input bit bp, input bit lat_chk, input string tag);
        int            n, sent, recv, cyc, r, c;
        bit            hold;
        logic [TW-1:0] hold_d;
        exp_t          e;
        n = H * W; sent = 0; recv = 0; cyc = 0; r = 0; c = 0;
        hold = 1'b0; hold_d = '0;
        while ((sent < n || recv < n) && cyc < 4 * n + 50) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== hold_d) begin
                    errors++;
                    $display("FAIL %s_stall_stable: valid=%0b data=%0h, expected 1/%0h", tag, m_tvalid, m_tdata, hold_d);
                end
            end
            m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n) begin
                r = sent / W; c = sent % W;
                s_tvalid = 1'b1; s_tdata = pix(f, r, c);
                s_tuser = (sent == 0); s_tlast = (c == W - 1);
            end else begin
                s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
            end
            #1;
            if (s_tvalid && s_tready) begin
                e.u = s_tuser; e.l = s_tlast; e.cyc = cyc;
                if (go_m && is_bad(r, c)) e.d = model_lg;
                else begin
                    e.d = s_tdata;
                    model_lg = s_tdata;
                end
                sb.push_back(e);
                sent++;
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_beat: data=%0h with nothing expected", tag, m_tdata);
                end else begin
                    e = sb.pop_front();
                    if ({m_tdata, m_tuser, m_tlast} !== {e.d, e.u, e.l}) begin
                        errors++;
                        $display("FAIL %s_beat%0d: data/user/last=%0h/%0b/%0b, expected %0h/%0b/%0b",
                                 tag, recv, m_tdata, m_tuser, m_tlast, e.d, e.u, e.l);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc != e.cyc + 1) begin
                            errors++;
                            $display("FAIL %s_latency%0d: %0d cycles, expected 1", tag, recv, cyc - e.cyc);
                        end
                    end
                end
                recv++;
                hold = 1'b0;
            end else begin
                hold = m_tvalid;
                hold_d = m_tdata;
            end
        end
        checks++;
        if (recv != n || sent != n || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_beat_count: sent=%0d received=%0d pending=%0d, expected %0d/%0d/0", tag, sent, recv, sb.size(), n, n);
            sb.delete();
        end
        @(negedge clk);
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: m_tvalid=%0b after frame, expected 0", tag, m_tvalid);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, m_tvalid, m_tuser, m_tlast} !== 8'h00) begin
            errors++;
            $display("FAIL reset_handshake: %b, expected 00000000", {awready, wready, bvalid, arready, rvalid, m_tvalid, m_tuser, m_tlast});
        end
        checks++;
        if (m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata: %0h, expected 0", m_tdata);
        end
        axi_read(32'h000, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: %0h, expected 0", d); end
        axi_read(32'h004, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_count: %0h, expected 0", d); end
        axi_read(32'h008, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_lut0: %0h, expected 0", d); end
    endtask

    task automatic test_bad_origin();
        axi_write(32'h008, 32'h0);
        axi_write(32'h004, 32'd1);
        axi_write(32'h000, 32'd1);
        bad_n = 1; bad_r[0] = 0; bad_c[0] = 0;
        run_frame(0, 1'b1, 1'b0, 1'b0, "origin");
    endtask

    task automatic test_regs();
        logic [31:0] words[5];
        logic [31:0] d;
        words[0] = {16'd156, 16'd29};
        words[1] = {16'd132, 16'd82};
        words[2] = {16'd133, 16'd82};
        words[3] = {16'd132, 16'd83};
        words[4] = {16'd133, 16'd83};
        axi_write(32'h004, 32'd5);
        for (int i = 0; i < 5; i++) axi_write(32'h008 + 32'(4 * i), words[i]);
        axi_read(32'h004, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL regs_count: %0d, expected 5", d); end
        for (int i = 0; i < 5; i++) begin
            axi_read(32'h008 + 32'(4 * i), d);
            checks++;
            if (d !== words[i]) begin errors++; $display("FAIL regs_lut%0d: %0h, expected %0h", i, d, words[i]); end
        end
        axi_write(32'h004, 32'd100);
        axi_read(32'h004, d);
        checks++;
        if (d !== 32'd64) begin errors++; $display("FAIL regs_count_sat: %0d, expected 64", d); end
        axi_write(32'h200, 32'hDEADBEEF);
        axi_read(32'h200, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL regs_unmapped: %0h, expected 0", d); end
        axi_read(32'h000, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL regs_ctrl: %0h, expected 1", d); end
    endtask

    task automatic test_correction();
        bad_n = 5;
        bad_r[0] = 2; bad_c[0] = 5;
        bad_r[1] = 4; bad_c[1] = 4;
        bad_r[2] = 4; bad_c[2] = 5;
        bad_r[3] = 5; bad_c[3] = 4;
        bad_r[4] = 5; bad_c[4] = 5;
        for (int i = 0; i < 5; i++) axi_write(32'h008 + 32'(4 * i), {16'(bad_c[i]), 16'(bad_r[i])});
        axi_write(32'h004, 32'd5);
        axi_write(32'h000, 32'd1);
        run_frame(1, 1'b1, 1'b0, 1'b0, "correct");
    endtask

    task automatic test_status();
        logic [31:0] d;
        logic [31:0] exp_d;
`ifdef DPC_STATUS_EN
        exp_d = 32'd5;
`else
        exp_d = 32'd0;
`endif
        axi_read(32'h3FC, d);
        checks++;
        if (d !== exp_d) begin errors++; $display("FAIL status: %0d, expected %0d", d, exp_d); end
    endtask

    task automatic test_passthrough();
        axi_write(32'h000, 32'd0);
        run_frame(2, 1'b0, 1'b0, 1'b1, "passthru");
    endtask

    task automatic test_backpressure();
        axi_write(32'h000, 32'd1);
        run_frame(1, 1'b1, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_go_toggle();
        fork
            run_frame(3, 1'b1, 1'b0, 1'b0, "go_off_mid");
            begin
                repeat (40) @(negedge clk);
                axi_write(32'h000, 32'd0);
            end
        join
        run_frame(4, 1'b0, 1'b0, 1'b0, "go_off_next");
        fork
            run_frame(5, 1'b0, 1'b0, 1'b0, "go_on_mid");
            begin
                repeat (40) @(negedge clk);
                axi_write(32'h000, 32'd1);
            end
        join
        run_frame(6, 1'b1, 1'b1, 1'b0, "go_on_next");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        m_tready = 1'b1;
        awaddr = '0; wdata = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_bad_origin();
        test_regs();
        test_correction();
        test_status();
        test_passthrough();
        test_backpressure();
        test_go_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
